// File: rtl/ahb_burst_master.sv
// ---------------------------------------------------------------------------
// ahb_burst_master
// AHB-Lite master that moves single transfers and INCR bursts between the
// edge-detection buffers and system SRAM. Address and data phases are
// pipelined. Wait states stall the bus, and an HRESP error aborts the rest of
// the burst. A beat whose address crosses a 1 KB boundary is reissued as
// NONSEQ.
//
// Ports
//   clk, n_rst              clock (rising edge), async active-low reset
//   re / we                 read / write request, sampled only in IDLE
//   new_raddr / new_waddr   start address for the read / write burst
//   burst_len               beats per burst (0 -> 1, > MAX_BURST -> MAX_BURST)
//   wr_data, wr_data_req    write source data; req pulses when a beat is taken
//   hready, hresp, hrdata   slave handshake, error and read data
//   haddr, htrans, hwrite,
//   hwdata                  AHB address/control and write data
//   rd_data, rd_valid       captured read beat and its one-cycle strobe
//   busy                    a burst is in progress
//   read_complete,
//   write_complete, error   one-cycle end-of-burst pulses
// ADDR_W must be at least 10 because the boundary check uses haddr[9:0].
// ---------------------------------------------------------------------------
module ahb_burst_master #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int ADDR_STEP = 4
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       re,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          new_raddr,
  input  logic [ADDR_W-1:0]          new_waddr,
  input  logic [$clog2(MAX_BURST):0] burst_len,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       wr_data_req,
  input  logic                       hready,
  input  logic                       hresp,
  input  logic [DATA_W-1:0]          hrdata,
  output logic [ADDR_W-1:0]          haddr,
  output logic [1:0]                 htrans,
  output logic                       hwrite,
  output logic [DATA_W-1:0]          hwdata,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       busy,
  output logic                       read_complete,
  output logic                       write_complete,
  output logic                       error
);

  localparam int LEN_W = $clog2(MAX_BURST) + 1;
  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_PIPE, S_LAST, S_ERR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   haddr_q, haddr_d;
  logic [LEN_W-1:0]    beats_q, beats_d;   // addresses still to issue after the current one
  logic                split_q, split_d;   // current PIPE beat restarts at a 1 KB boundary
  logic                hwrite_q, hwrite_d;
  logic [DATA_W-1:0]   hwdata_q, hwdata_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_cmp_q, rd_cmp_d;
  logic                wr_cmp_q, wr_cmp_d;
  logic                err_q, err_d;

  logic [LEN_W-1:0]    len_eff;
  logic [ADDR_W-1:0]   haddr_inc;
  logic                crosses;
  logic                addr_acc;

  // Normalise the requested length: zero means one beat, oversize is clamped.
  always_comb begin
    len_eff = burst_len;
    if (burst_len == '0)                         len_eff = LEN_W'(1);
    else if (burst_len > LEN_W'(MAX_BURST))      len_eff = LEN_W'(MAX_BURST);
  end

  assign haddr_inc = haddr_q + ADDR_W'(ADDR_STEP);
  assign crosses   = haddr_inc[9:0] < haddr_q[9:0];

  // An address phase is taken on this edge. An erroring data phase in PIPE
  // cancels the overlapping address, so no write beat is consumed for it.
  assign addr_acc = hready & ((state_q == S_ADDR) | ((state_q == S_PIPE) & ~hresp));

  always_comb begin
    state_d    = state_q;
    haddr_d    = haddr_q;
    beats_d    = beats_q;
    split_d    = split_q;
    hwrite_d   = hwrite_q;
    hwdata_d   = hwdata_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_cmp_d   = 1'b0;
    wr_cmp_d   = 1'b0;
    err_d      = 1'b0;

    // Write data is registered with its address so it spans the data phase.
    if (addr_acc && hwrite_q) hwdata_d = wr_data;

    case (state_q)
      S_IDLE: begin
        if (re) begin
          haddr_d  = new_raddr;
          beats_d  = len_eff - LEN_W'(1);
          hwrite_d = 1'b0;
          split_d  = 1'b0;
          state_d  = S_ADDR;
        end else if (we) begin
          haddr_d  = new_waddr;
          beats_d  = len_eff - LEN_W'(1);
          hwrite_d = 1'b1;
          split_d  = 1'b0;
          state_d  = S_ADDR;
        end
      end

      S_ADDR, S_PIPE: begin
        if (state_q == S_PIPE && hresp) begin
          // First error cycle (hready low) drops to IDLE on the bus via ERR.
          if (hready) begin
            err_d    = 1'b1;
            hwrite_d = 1'b0;
            state_d  = S_IDLE;
          end else begin
            state_d  = S_ERR;
          end
        end else if (hready) begin
          if (state_q == S_PIPE && !hwrite_q) begin
            rd_data_d  = hrdata;
            rd_valid_d = 1'b1;
          end
          if (beats_q == '0) begin
            state_d = S_LAST;
          end else begin
            haddr_d = haddr_inc;
            beats_d = beats_q - LEN_W'(1);
            split_d = crosses;
            state_d = S_PIPE;
          end
        end
      end

      S_LAST: begin
        if (hresp) begin
          if (hready) begin
            err_d    = 1'b1;
            hwrite_d = 1'b0;
            state_d  = S_IDLE;
          end else begin
            state_d  = S_ERR;
          end
        end else if (hready) begin
          if (!hwrite_q) begin
            rd_data_d  = hrdata;
            rd_valid_d = 1'b1;
          end
          rd_cmp_d = ~hwrite_q;
          wr_cmp_d = hwrite_q;
          hwrite_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      S_ERR: begin
        if (hready) begin
          err_d    = 1'b1;
          hwrite_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      haddr_q    <= '0;
      beats_q    <= '0;
      split_q    <= 1'b0;
      hwrite_q   <= 1'b0;
      hwdata_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_cmp_q   <= 1'b0;
      wr_cmp_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      haddr_q    <= haddr_d;
      beats_q    <= beats_d;
      split_q    <= split_d;
      hwrite_q   <= hwrite_d;
      hwdata_q   <= hwdata_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_cmp_q   <= rd_cmp_d;
      wr_cmp_q   <= wr_cmp_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    htrans = HT_IDLE;
    case (state_q)
      S_ADDR:  htrans = HT_NONSEQ;
      S_PIPE:  htrans = split_q ? HT_NONSEQ : HT_SEQ;
      default: htrans = HT_IDLE;
    endcase
  end

  assign haddr          = haddr_q;
  assign hwrite         = hwrite_q;
  assign hwdata         = hwdata_q;
  assign rd_data        = rd_data_q;
  assign rd_valid       = rd_valid_q;
  assign busy           = (state_q != S_IDLE);
  assign wr_data_req    = addr_acc & hwrite_q;
  assign read_complete  = rd_cmp_q;
  assign write_complete = wr_cmp_q;
  assign error          = err_q;

endmodule

// File: tb/tb_ahb_burst_master.sv
// ---------------------------------------------------------------------------
// tb_ahb_burst_master
// Self-checking bench for ahb_burst_master. A table of bursts with
// hand-computed results, hand-written cycle-exact sequences for waits, errors
// and reset, and randomised bursts with random wait states. All of these are
// scored against a transaction-level model of the expected bus activity.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ahb_burst_master;

  logic        clk, n_rst;
  logic        re, we;
  logic [31:0] new_raddr, new_waddr;
  logic [4:0]  burst_len;
  logic [31:0] wr_data;
  logic        wr_data_req;
  logic        hready, hresp;
  logic [31:0] hrdata;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] hwdata, rd_data;
  logic        rd_valid, busy, read_complete, write_complete, error;

  ahb_burst_master dut (
    .clk(clk), .n_rst(n_rst), .re(re), .we(we),
    .new_raddr(new_raddr), .new_waddr(new_waddr), .burst_len(burst_len),
    .wr_data(wr_data), .wr_data_req(wr_data_req),
    .hready(hready), .hresp(hresp), .hrdata(hrdata),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hwdata(hwdata),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .read_complete(read_complete), .write_complete(write_complete), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Bus monitor state (updated once per cycle at the negedge).
  logic [31:0] aq_addr[$];
  logic [1:0]  aq_tr[$];
  logic        aq_wr[$];
  logic [31:0] wq[$];
  logic [31:0] rdq[$];
  int n_rc, n_wc, n_err, n_req, dcnt, widx;
  bit dpend, dwr;
  logic [31:0] pat [0:16];
  logic [31:0] src [0:16];

  logic [1:0]  s_htrans;
  logic [31:0] s_haddr, s_hwdata;
  logic        s_hwrite, s_busy, s_rc, s_wc, s_err, s_wreq;

  task automatic clear_mon();
    aq_addr.delete(); aq_tr.delete(); aq_wr.delete(); wq.delete(); rdq.delete();
    n_rc = 0; n_wc = 0; n_err = 0; n_req = 0; dcnt = 0; widx = 0;
    dpend = 1'b0; dwr = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      pat[i] = $urandom;
      src[i] = $urandom;
    end
    hrdata  = pat[0];
    wr_data = src[0];
  endtask

  // One bus cycle: observe at negedge with this cycle's inputs, then advance
  // the slave read data and write source to follow the protocol.
  task automatic tick();
    @(negedge clk);
    s_htrans = htrans; s_haddr = haddr; s_hwrite = hwrite; s_hwdata = hwdata;
    s_busy = busy; s_rc = read_complete; s_wc = write_complete; s_err = error;
    s_wreq = wr_data_req;
    if (dpend && hready) begin
      if (!hresp && dwr) wq.push_back(hwdata);
      dcnt++;
      dpend = 1'b0;
    end
    if (htrans != 2'b00 && hready) begin
      aq_addr.push_back(haddr); aq_tr.push_back(htrans); aq_wr.push_back(hwrite);
      dpend = 1'b1;
      dwr   = hwrite;
    end
    if (rd_valid) rdq.push_back(rd_data);
    if (wr_data_req) begin widx++; n_req++; end
    if (read_complete)  n_rc++;
    if (write_complete) n_wc++;
    if (error)          n_err++;
    @(posedge clk);
    #1;
    hrdata  = pat[(dcnt > 16) ? 16 : dcnt];
    wr_data = src[(widx > 16) ? 16 : widx];
  endtask

  task automatic run_burst(input bit r, input bit w, input logic [31:0] ra, input logic [31:0] wa,
                           input logic [4:0] bl, input bit rw, output int lat);
    clear_mon();
    re = r; we = w; new_raddr = ra; new_waddr = wa; burst_len = bl;
    hready = rw ? 1'($urandom_range(0, 1)) : 1'b1;
    hresp = 1'b0;
    tick();
    re = 1'b0; we = 1'b0;
    lat = -1;
    for (int c = 1; c <= 400; c++) begin
      hready = rw ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      if (s_rc || s_wc || s_err) begin
        lat = c;
        break;
      end
    end
    chk("burst_timeout", (lat < 0), 0);
    hready = 1'b1;
    tick();
    tick();
  endtask

  // Expected bus activity for a request, from the burst rules alone.
  task automatic check_model(input bit rd, input logic [31:0] ra, input logic [31:0] wa, input int bl);
    int n;
    logic [31:0] base, a, prev;
    logic [1:0] tr;
    base = rd ? ra : wa;
    n = (bl == 0) ? 1 : ((bl > 16) ? 16 : bl);
    chk("beats", aq_addr.size(), n);
    for (int i = 0; i < n && i < aq_addr.size(); i++) begin
      a    = base + 32'(4 * i);
      prev = base + 32'(4 * (i - 1));
      tr   = (i == 0 || ((prev % 1024) + 4 >= 1024)) ? 2'b10 : 2'b11;
      chk("haddr", aq_addr[i], a);
      chk("htrans", aq_tr[i], tr);
      chk("hwrite", aq_wr[i], !rd);
    end
    if (rd) begin
      chk("rd_count", rdq.size(), n);
      for (int i = 0; i < n && i < rdq.size(); i++) chk("rd_data", rdq[i], pat[i]);
      chk("wr_req_count", n_req, 0);
    end else begin
      chk("wdata_count", wq.size(), n);
      for (int i = 0; i < n && i < wq.size(); i++) chk("hwdata", wq[i], src[i]);
      chk("wr_req_count", n_req, n);
    end
    chk("read_complete_count", n_rc, rd);
    chk("write_complete_count", n_wc, !rd);
    chk("error_count", n_err, 0);
  endtask

  typedef struct {
    bit          re, we;
    logic [31:0] ra, wa;
    logic [4:0]  bl;
    bit          ehw;
    int          en;
    logic [31:0] elast;
    int          ens;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, ns, rc_cyc;
    bit hs[8];
    bit rr, ww;
    logic [31:0] ra, wa;
    logic [4:0] bl;

    tbl[0] = '{1'b0, 1'b1, 32'h0,        32'h10,  5'd1,  1'b1, 1,  32'h10,       1};
    tbl[1] = '{1'b1, 1'b0, 32'h100,      32'h0,   5'd4,  1'b0, 4,  32'h10C,      1};
    tbl[2] = '{1'b0, 1'b1, 32'h0,        32'h3F8, 5'd4,  1'b1, 4,  32'h404,      2};
    tbl[3] = '{1'b1, 1'b1, 32'h200,      32'h800, 5'd2,  1'b0, 2,  32'h204,      1};
    tbl[4] = '{1'b0, 1'b1, 32'h0,        32'h40,  5'd0,  1'b1, 1,  32'h40,       1};
    tbl[5] = '{1'b1, 1'b0, 32'h1000,     32'h0,   5'd20, 1'b0, 16, 32'h103C,     1};
    tbl[6] = '{1'b1, 1'b0, 32'hFFFFFFF8, 32'h0,   5'd16, 1'b0, 16, 32'h00000034, 2};
    tbl[7] = '{1'b0, 1'b1, 32'h0,        32'h7FC, 5'd31, 1'b1, 16, 32'h838,      2};

    n_rst = 1'b0; re = 1'b0; we = 1'b0; new_raddr = '0; new_waddr = '0;
    burst_len = '0; wr_data = '0; hready = 1'b0; hresp = 1'b0; hrdata = '0;
    clear_mon();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_htrans", htrans, 0);
    chk("reset_busy", busy, 0);
    chk("reset_outputs", {haddr, hwrite, hwdata, rd_data, rd_valid, read_complete,
                          write_complete, error, wr_data_req}, 0);
    n_rst = 1'b1;

    // Spurious hready in IDLE: nothing happens on the bus.
    hready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_htrans", s_htrans, 0);
    end
    chk("idle_pulses", n_rc + n_wc + n_err, 0);

    // Single write, cycle by cycle.
    clear_mon();
    src[0] = 32'hAAAAAAAA; wr_data = src[0];
    we = 1'b1; new_waddr = 32'h10; burst_len = 5'd1; hready = 1'b1;
    tick();
    we = 1'b0;
    tick();
    chk("sw_htrans", s_htrans, 2'b10);
    chk("sw_haddr", s_haddr, 32'h10);
    chk("sw_hwrite", s_hwrite, 1);
    chk("sw_wr_data_req", s_wreq, 1);
    tick();
    chk("sw_hwdata", s_hwdata, 32'hAAAAAAAA);
    chk("sw_last_htrans", s_htrans, 0);
    chk("sw_last_busy", s_busy, 1);
    tick();
    chk("sw_write_complete", s_wc, 1);
    chk("sw_busy_done", s_busy, 0);
    tick();
    chk("sw_complete_once", s_wc, 0);

    // Table of bursts with zero wait states.
    foreach (tbl[k]) begin
      run_burst(tbl[k].re, tbl[k].we, tbl[k].ra, tbl[k].wa, tbl[k].bl, 1'b0, lat);
      chk("tbl_latency", lat, tbl[k].en + 2);
      chk("tbl_hwrite", (aq_wr.size() > 0) ? aq_wr[0] : 1'bx, tbl[k].ehw);
      chk("tbl_last_addr", (aq_addr.size() > 0) ? aq_addr[aq_addr.size()-1] : 32'hx, tbl[k].elast);
      ns = 0;
      foreach (aq_tr[j]) if (aq_tr[j] == 2'b10) ns++;
      chk("tbl_nonseq_count", ns, tbl[k].ens);
      check_model(tbl[k].re, tbl[k].ra, tbl[k].wa, int'(tbl[k].bl));
    end

    // 4-beat read, two wait states on the second data phase.
    clear_mon();
    pat[0] = 32'hFFFFFFFF; pat[1] = 32'h0; pat[2] = 32'hAAAAAAAA; pat[3] = 32'h55555555;
    hrdata = pat[0];
    re = 1'b1; new_raddr = 32'h100; burst_len = 5'd4; hready = 1'b1;
    tick();
    re = 1'b0;
    hs = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    rc_cyc = -1;
    for (int c = 0; c < 8; c++) begin
      hready = hs[c];
      tick();
      if (c >= 2 && c <= 4) begin
        chk("wait_haddr_held", s_haddr, 32'h108);
        chk("wait_htrans_held", s_htrans, 2'b11);
      end
      if (s_rc && rc_cyc < 0) rc_cyc = c + 1;
    end
    chk("wait_complete_cycle", rc_cyc, 8);
    hready = 1'b1;
    tick();
    check_model(1'b1, 32'h100, 32'h0, 4);

    // HRESP error on the second beat of a 4-beat read.
    clear_mon();
    re = 1'b1; new_raddr = 32'h200; burst_len = 5'd4; hready = 1'b1; hresp = 1'b0;
    tick();
    re = 1'b0;
    tick();
    tick();
    hresp = 1'b1; hready = 1'b0;
    tick();
    hready = 1'b1;
    tick();
    chk("err_htrans_idle", s_htrans, 0);
    hresp = 1'b0;
    tick();
    chk("err_pulse", s_err, 1);
    tick();
    chk("err_pulse_once", s_err, 0);
    tick();
    tick();
    chk("err_count", n_err, 1);
    chk("err_no_complete", n_rc + n_wc, 0);
    chk("err_rd_valid_count", rdq.size(), 1);
    chk("err_rd_data", (rdq.size() > 0) ? rdq[0] : 32'hx, pat[0]);

    // Reset in the middle of a write burst.
    clear_mon();
    we = 1'b1; new_waddr = 32'h500; burst_len = 5'd8; hready = 1'b1;
    tick();
    we = 1'b0;
    tick();
    tick();
    tick();
    #2;
    n_rst = 1'b0;
    #1;
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_htrans", htrans, 0);
    chk("mid_reset_outputs", {haddr, hwrite, hwdata, wr_data_req, rd_valid}, 0);
    tick();
    tick();
    n_rst = 1'b1;
    tick();
    tick();
    tick();
    chk("mid_reset_no_pulse", n_rc + n_wc + n_err, 0);

    // Randomised bursts with random wait states.
    for (int t = 0; t < 40; t++) begin
      rr = 1'($urandom_range(0, 1));
      ww = 1'($urandom_range(0, 1));
      if (!rr && !ww) ww = 1'b1;
      ra = $urandom & ~32'h3;
      wa = $urandom & ~32'h3;
      if ($urandom_range(0, 1) == 1) begin
        ra = (ra & ~32'h3FF) | (32'h400 - 32'(4 * $urandom_range(1, 6)));
        wa = (wa & ~32'h3FF) | (32'h400 - 32'(4 * $urandom_range(1, 6)));
      end
      bl = 5'($urandom_range(0, 31));
      run_burst(rr, ww, ra, wa, bl, 1'b1, lat);
      check_model(rr, ra, wa, int'(bl));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_burst_master.md
Name: ahb_burst_master

Overview:
- Parametrised AHB-Lite master for the edge-detection datapath.
- Moves single transfers and INCR bursts between the internal buffers and SRAM on the system bus.
- Generalises the single-beat read/write master with configurable address/data width and burst length.
- Adds pipelined address/data phases, wait-state handling, HRESP error abort and 1 KB boundary splitting.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data width in bits
MAX_BURST, 16, maximum beats per request
ADDR_STEP, 4, byte increment per beat

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
re  in  1  read request, sampled in IDLE
we  in  1  write request, sampled in IDLE
new_raddr  in  ADDR_W  read start address
new_waddr  in  ADDR_W  write start address
burst_len  in  $clog2(MAX_BURST)+1  beats, sampled with request; 0 treated as 1, >MAX_BURST clamped
wr_data  in  DATA_W  write data for next beat from buffer
wr_data_req  out  1  pulse: wr_data consumed, source advances
hready  in  1  slave ready
hresp  in  1  slave error response
hrdata  in  DATA_W  bus read data
haddr  out  ADDR_W  bus address
htrans  out  2  00 IDLE, 10 NONSEQ, 11 SEQ
hwrite  out  1  1 = write transfer
hwdata  out  DATA_W  bus write data
rd_data  out  DATA_W  captured read beat
rd_valid  out  1  pulse: rd_data valid
busy  out  1  transfer in progress
read_complete  out  1  1-cycle pulse, read burst done
write_complete  out  1  1-cycle pulse, write burst done
error  out  1  1-cycle pulse, burst aborted by hresp

Behaviour:
- Reset (async, any state): all outputs 0; state IDLE; beat counters cleared.
- States: IDLE, ADDR, PIPE, LAST, ERR.
- IDLE:
  - re=1 at a posedge: latch new_raddr, burst_len, hwrite=0; go to ADDR.
  - else we=1: latch new_waddr, hwrite=1; go to ADDR.
  - re and we both 1: read wins, write dropped, not queued.
  - hready/hresp ignored; no complete or error pulse.
- ADDR: htrans=NONSEQ, haddr=start, busy=1.
  - Address phase accepted at posedge with hready=1.
  - Then go to PIPE if beats remain, else LAST.
- PIPE: data phase of beat i overlaps address phase of beat i+1.
  - haddr advances by ADDR_STEP modulo 2^ADDR_W; htrans=SEQ.
  - If the increment crosses a 1 KB boundary (haddr[9:0] wraps), that beat is issued as NONSEQ.
  - hready=0: haddr, htrans, hwrite, hwdata held stable.
  - After the final address phase is accepted, go to LAST.
- LAST: htrans=IDLE; last data phase completes on hready=1.
  - Next cycle: read_complete or write_complete pulses for one cycle, busy=0, return to IDLE.
  - A request may be sampled on that same cycle.
- Write data:
  - wr_data_req = hwrite & address phase accepted this cycle.
  - hwdata <= wr_data on that edge, so it is valid for the whole matching data phase.
- Read data:
  - On each data phase completing with hready=1 and hresp=0: rd_data <= hrdata, rd_valid pulses next cycle.
- Latency:
  - Request to NONSEQ on bus: 1 cycle.
  - N-beat zero-wait burst: complete pulse N+2 cycles after the request edge.
- Error:
  - hresp=1 with hready=0 (first error cycle): next cycle htrans=IDLE, remaining beats cancelled, go to ERR.
  - ERR: waits for hready=1, pulses error 1 cycle, returns to IDLE.
  - No complete pulse, no rd_valid for the errored beat.
- Requests while busy=1 are ignored.
- Reset mid-burst aborts the burst with no complete or error pulse.

Test Plan:
- Single write, zero wait: we=1, new_waddr=0x10, burst_len=1, wr_data=0xAAAAAAAA, hready=1 → next cycle NONSEQ haddr=0x10 hwrite=1; then hwdata=0xAAAAAAAA; write_complete pulse 3 cycles after request.
- 4-beat read, 2 wait states on beat 2: re=1, new_raddr=0x100, burst_len=4, hrdata=0xFFFFFFFF, 0x0, 0xAAAAAAAA, 0x55555555 → haddr 0x100/104/108/10C with NONSEQ,SEQ,SEQ,SEQ; haddr held during waits; 4 rd_valid pulses in order; one read_complete.
- 1 KB split: write burst_len=4 from 0x3F8 → htrans NONSEQ,SEQ,NONSEQ,SEQ at 0x3F8/3FC/400/404.
- Simultaneous re=we=1 → hwrite=0, read executes, no write_complete ever.
- Spurious hready=1 in IDLE after reset with no request → no complete or error pulse, htrans=00.
- hresp on beat 2 of 4-beat read (hresp=1 hready=0, then hresp=1 hready=1) → htrans=IDLE next cycle, error pulses once, no read_complete, only 1 rd_valid; reset asserted mid-burst → all outputs 0 immediately.
